// File: rtl/sif_nnz_count.sv
// -----------------------------------------------------------------------------
// sif_nnz_count
//
// Upstream feeder for the fixed-point-in / floating-point-out divider stage.
// It watches a multi-lane activation stream and counts two things per tile:
// how many elements were valid, and how many of those were non-zero.
// A tile ends on the beat that carries in_last.
//
// For every finished tile it produces one operand pair for the divider:
//   divisor  (A) = total valid element count
//   dividend (B) = non-zero element count
// The divider then computes the density that the sparse multi-DNN scheduler
// uses. Finished pairs wait in a small result FIFO, so the input side keeps
// running while the divider is not accepting.
//
// Parameters:
//   DATA_W    - width of one activation element
//   LANES     - elements per input beat (1..8)
//   OUT_DEPTH - result FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_vld / in_rdy  - input beat handshake
//   in_dat           - lane i occupies bits [i*DATA_W +: DATA_W]
//   in_keep          - per-lane element-valid mask
//   in_last          - final beat of the tile
//   A_vld / A_dat    - divisor valid / divisor (total count)
//   B_vld / B_dat    - dividend valid / dividend (non-zero count)
//   out_rdy          - downstream accept (tie high if the divider has no ready)
//
// Optional build macro SIF_NNZ_STATS_EN adds two status outputs:
//   stat_tiles - wrapping count of tiles pushed into the FIFO
//   stat_sat   - sticky flag, set when either counter saturated
// -----------------------------------------------------------------------------
module sif_nnz_count #(
    parameter int DATA_W    = 16,
    parameter int LANES     = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [LANES*DATA_W-1:0] in_dat,
    input  logic [LANES-1:0]        in_keep,
    input  logic                    in_last,
    output logic                    in_rdy,
    output logic                    A_vld,
    output logic [15:0]             A_dat,
    output logic                    B_vld,
    output logic [15:0]             B_dat,
    input  logic                    out_rdy
`ifdef SIF_NNZ_STATS_EN
    ,
    output logic [31:0]             stat_tiles,
    output logic                    stat_sat
`endif
);

    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Running per-tile counters; they are zero whenever the FSM is in IDLE.
    logic [15:0] tot_cnt;
    logic [15:0] nnz_cnt;

    // Per-beat lane counts (at most 8 lanes, so 4 bits are enough).
    logic [3:0]  beat_tot;
    logic [3:0]  beat_nnz;

    // 17-bit sums expose the carry, which drives saturation.
    logic [16:0] sum_tot;
    logic [16:0] sum_nnz;
    logic [15:0] sat_tot;
    logic [15:0] sat_nnz;
    logic [15:0] push_tot;

    logic        accept;
    logic        push;
    logic        pop;
    logic        cnt_upd;
    logic        cnt_clr;

    // Result FIFO storage and pointers.
    logic [15:0]   mem_tot [OUT_DEPTH];
    logic [15:0]   mem_nnz [OUT_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;

    // Ready is held low through reset and comes up one clock after release.
    // It therefore depends only on registered state and never on in_vld.
    logic rdy_en;

    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign fifo_empty = (fifo_cnt == '0);

    assign in_rdy = rdy_en & ~fifo_full;
    assign accept = in_vld & in_rdy;
    assign pop    = ~fifo_empty & out_rdy;

    // Count the valid lanes in this beat, and the valid lanes that hold a
    // non-zero value. A lane with in_keep low is ignored whatever it carries.
    always_comb begin
        beat_tot = 4'd0;
        beat_nnz = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            if (in_keep[i]) begin
                beat_tot = beat_tot + 4'd1;
                if (in_dat[i*DATA_W +: DATA_W] != '0) begin
                    beat_nnz = beat_nnz + 4'd1;
                end
            end
        end
    end

    // Add the beat to the running counts, clamping at 0xFFFF. The same
    // saturated values feed both the accumulator and the FIFO push, so a
    // pushed tile always includes its own last beat.
    always_comb begin
        sum_tot  = {1'b0, tot_cnt} + 17'(beat_tot);
        sum_nnz  = {1'b0, nnz_cnt} + 17'(beat_nnz);
        sat_tot  = sum_tot[16] ? 16'hFFFF : sum_tot[15:0];
        sat_nnz  = sum_nnz[16] ? 16'hFFFF : sum_nnz[15:0];
        // An empty tile reports divisor 1 so the divider never divides by 0.
        push_tot = (sat_tot == 16'd0) ? 16'd1 : sat_tot;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A last beat pushes the finished tile and clears the
    // counters. Any other accepted beat adds to the counters.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        cnt_upd = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        push    = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_upd = 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        push    = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_upd = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Tile accumulators. Clearing has priority, so the counters read zero on
    // the cycle after a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tot_cnt <= 16'd0;
            nnz_cnt <= 16'd0;
        end else if (cnt_clr) begin
            tot_cnt <= 16'd0;
            nnz_cnt <= 16'd0;
        end else if (cnt_upd) begin
            tot_cnt <= sat_tot;
            nnz_cnt <= sat_nnz;
        end
    end

    // Input-ready enable. It comes up on the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // FIFO storage. It is not reset, because entries are only visible while
    // the occupancy count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_tot[wr_ptr] <= push_tot;
            mem_nnz[wr_ptr] <= sat_nnz;
        end
    end

    // FIFO pointers and occupancy. Push is never asserted when the FIFO is
    // full, because in_rdy is low then. A push and a pop in the same cycle
    // leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Both output channels show the same FIFO head entry. Data reads zero
    // while the FIFO is empty, which includes reset.
    always_comb begin
        A_vld = ~fifo_empty;
        B_vld = ~fifo_empty;
        A_dat = fifo_empty ? 16'd0 : mem_tot[rd_ptr];
        B_dat = fifo_empty ? 16'd0 : mem_nnz[rd_ptr];
    end

`ifdef SIF_NNZ_STATS_EN
    // Tile counter (wrapping), and a sticky saturation flag. The flag is set
    // whenever an accepted beat would carry either counter past 0xFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_tiles <= 32'd0;
            stat_sat   <= 1'b0;
        end else begin
            if (push) begin
                stat_tiles <= stat_tiles + 32'd1;
            end
            if (accept && (sum_tot[16] || sum_nnz[16])) begin
                stat_sat <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sif_nnz_count.sv
// -----------------------------------------------------------------------------
// tb_sif_nnz_count
//
// Self-checking bench for sif_nnz_count (LANES=4, DATA_W=16, OUT_DEPTH=2).
//
// A queue-based reference model tracks the per-tile sums, the result FIFO
// contents and the input ready. It checks the DUT every cycle. On top of that
// model, table vectors and hand-written sequences compare against fixed
// expected values.
// -----------------------------------------------------------------------------
module tb_sif_nnz_count;

    localparam int DATA_W    = 16;
    localparam int LANES     = 4;
    localparam int OUT_DEPTH = 2;

    logic                    clk;
    logic                    rst;
    logic                    in_vld;
    logic [LANES*DATA_W-1:0] in_dat;
    logic [LANES-1:0]        in_keep;
    logic                    in_last;
    logic                    in_rdy;
    logic                    A_vld;
    logic [15:0]             A_dat;
    logic                    B_vld;
    logic [15:0]             B_dat;
    logic                    out_rdy;
`ifdef SIF_NNZ_STATS_EN
    logic [31:0]             stat_tiles;
    logic                    stat_sat;
`endif

    int total;
    int bad;

    // Reference model state
    int           m_tot;
    int           m_nnz;
    logic [31:0]  m_q[$];
    bit           m_rdy_ok;
    int           m_tiles;
    bit           m_sat;

    typedef struct {
        logic [3:0]  keep;
        logic [63:0] dat;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[6];

    sif_nnz_count #(
        .DATA_W   (DATA_W),
        .LANES    (LANES),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_dat    (in_dat),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_rdy    (in_rdy),
        .A_vld     (A_vld),
        .A_dat     (A_dat),
        .B_vld     (B_vld),
        .B_dat     (B_dat),
        .out_rdy   (out_rdy)
`ifdef SIF_NNZ_STATS_EN
        ,
        .stat_tiles(stat_tiles),
        .stat_sat  (stat_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog, so the run always ends on its own.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [3:0] keep, input logic [63:0] dat,
                                 input logic last, input logic ordy);
        in_vld  = vld;
        in_keep = keep;
        in_dat  = dat;
        in_last = last;
        out_rdy = ordy;
    endtask

    // Compare the DUT against the model for the current cycle. Then advance
    // the model and step to 1ns past the next rising edge.
    task automatic cycleCheck();
        bit acc;
        bit pop;
        bit exp_rdy;
        int ta;
        int tb;
        exp_rdy = m_rdy_ok && (m_q.size() < OUT_DEPTH);
        checkOutput("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
        checkOutput("A_vld", {31'd0, A_vld}, {31'd0, m_q.size() > 0});
        checkOutput("B_vld", {31'd0, B_vld}, {31'd0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            checkOutput("A_dat", {16'd0, A_dat}, {16'd0, m_q[0][31:16]});
            checkOutput("B_dat", {16'd0, B_dat}, {16'd0, m_q[0][15:0]});
        end
`ifdef SIF_NNZ_STATS_EN
        checkOutput("stat_tiles", stat_tiles, m_tiles);
        checkOutput("stat_sat", {31'd0, stat_sat}, {31'd0, m_sat});
`endif
        acc = in_vld && exp_rdy;
        pop = (m_q.size() > 0) && out_rdy;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_keep[i]) begin
                    m_tot++;
                    if (in_dat[i*DATA_W +: DATA_W] != 0) m_nnz++;
                end
            end
            if (m_tot > 65535 || m_nnz > 65535) m_sat = 1'b1;
            if (in_last) begin
                ta = (m_tot > 65535) ? 65535 : m_tot;
                tb = (m_nnz > 65535) ? 65535 : m_nnz;
                if (ta == 0) ta = 1;
                m_q.push_back({ta[15:0], tb[15:0]});
                m_tiles++;
                m_tot = 0;
                m_nnz = 0;
            end
        end
        @(posedge clk);
        #1;
        m_rdy_ok = 1'b1;
    endtask

    // Assert reset part-way into a cycle and check that it takes effect
    // immediately. Then release it just after a clock edge.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        checkOutput("rst_A_vld", {31'd0, A_vld}, 32'd0);
        checkOutput("rst_B_vld", {31'd0, B_vld}, 32'd0);
        checkOutput("rst_A_dat", {16'd0, A_dat}, 32'd0);
        checkOutput("rst_B_dat", {16'd0, B_dat}, 32'd0);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        m_q.delete();
        m_tot    = 0;
        m_nnz    = 0;
        m_rdy_ok = 1'b0;
        m_tiles  = 0;
        m_sat    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycleCheck();
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) cycleCheck();
    endtask

    initial begin
        logic [63:0] rd;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        m_rdy_ok = 1'b0;

        vecs[0] = '{keep: 4'b1111, dat: 64'h0000_0005_0000_0007, ea: 16'd4, eb: 16'd2};
        vecs[1] = '{keep: 4'b0000, dat: 64'h1111_2222_3333_4444, ea: 16'd1, eb: 16'd0};
        vecs[2] = '{keep: 4'b0001, dat: 64'h0000_0000_0000_0009, ea: 16'd1, eb: 16'd1};
        vecs[3] = '{keep: 4'b0101, dat: 64'h8000_0003_FFFF_0000, ea: 16'd2, eb: 16'd1};
        vecs[4] = '{keep: 4'b1010, dat: 64'h8000_0000_FFFF_0000, ea: 16'd2, eb: 16'd2};
        vecs[5] = '{keep: 4'b1111, dat: 64'h0000_0000_0000_0000, ea: 16'd4, eb: 16'd0};

        #3;
        doReset();
        checkOutput("rdy_after_release", {31'd0, in_rdy}, 32'd1);

        // Table: single-beat tiles, each emitted one cycle after its beat.
        foreach (vecs[k]) begin
            applyStimulus(1'b1, vecs[k].keep, vecs[k].dat, 1'b1, 1'b1);
            cycleCheck();
            applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
            checkOutput("vec_A_vld", {31'd0, A_vld}, 32'd1);
            checkOutput("vec_A_dat", {16'd0, A_dat}, {16'd0, vecs[k].ea});
            checkOutput("vec_B_dat", {16'd0, B_dat}, {16'd0, vecs[k].eb});
            cycleCheck();
        end

        // Three-beat tile.
        applyStimulus(1'b1, 4'b1111, 64'h0004_0003_0000_0001, 1'b0, 1'b1);
        cycleCheck();
        applyStimulus(1'b1, 4'b0011, 64'hAAAA_BBBB_0006_0005, 1'b0, 1'b1);
        cycleCheck();
        checkOutput("t3_no_early_vld", {31'd0, A_vld}, 32'd0);
        applyStimulus(1'b1, 4'b1000, 64'h0009_0000_1234_0000, 1'b1, 1'b1);
        cycleCheck();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("t3_A_dat", {16'd0, A_dat}, 32'd7);
        checkOutput("t3_B_dat", {16'd0, B_dat}, 32'd6);
        idleCycles(2);

        // Backpressure: the FIFO fills, the third tile is held, then drains.
        applyStimulus(1'b1, 4'b0001, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
        cycleCheck();
        applyStimulus(1'b1, 4'b0011, 64'h0000_0000_0002_0000, 1'b1, 1'b0);
        cycleCheck();
        applyStimulus(1'b1, 4'b0111, 64'h0000_0003_0002_0001, 1'b1, 1'b0);
        checkOutput("bp_rdy_low", {31'd0, in_rdy}, 32'd0);
        cycleCheck();
        cycleCheck();
        checkOutput("bp_head_A", {16'd0, A_dat}, 32'd1);
        out_rdy = 1'b1;
        cycleCheck();
        checkOutput("bp_second_A", {16'd0, A_dat}, 32'd2);
        cycleCheck();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("bp_third_A", {16'd0, A_dat}, 32'd3);
        checkOutput("bp_third_B", {16'd0, B_dat}, 32'd3);
        idleCycles(2);

        // Back-to-back single-beat tiles at one tile per cycle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 64'h0001_0001_0001_0001, 1'b1, 1'b1);
            cycleCheck();
        end
        idleCycles(2);

        // Reset in the middle of a tile, with one entry queued.
        applyStimulus(1'b1, 4'b0001, 64'h0000_0000_0000_0005, 1'b1, 1'b0);
        cycleCheck();
        applyStimulus(1'b1, 4'b1111, 64'h0001_0002_0003_0004, 1'b0, 1'b0);
        cycleCheck();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        checkOutput("mid_A_vld_pre", {31'd0, A_vld}, 32'd1);
        doReset();
        applyStimulus(1'b1, 4'b0001, 64'h0000_0000_0000_0009, 1'b1, 1'b1);
        cycleCheck();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("mid_A_dat", {16'd0, A_dat}, 32'd1);
        checkOutput("mid_B_dat", {16'd0, B_dat}, 32'd1);
        idleCycles(2);

        // Saturation: 16401 beats of four non-zero lanes.
        doReset();
        applyStimulus(1'b1, 4'b1111, 64'h0001_0002_0003_0004, 1'b0, 1'b1);
        for (int i = 0; i < 16400; i++) cycleCheck();
        in_last = 1'b1;
        cycleCheck();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("sat_A_dat", {16'd0, A_dat}, 32'h0000FFFF);
        checkOutput("sat_B_dat", {16'd0, B_dat}, 32'h0000FFFF);
`ifdef SIF_NNZ_STATS_EN
        checkOutput("sat_stat_sat", {31'd0, stat_sat}, 32'd1);
        checkOutput("sat_stat_tiles", stat_tiles, 32'd1);
`endif
        idleCycles(2);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rd = 64'd0;
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 1) == 1) rd[l*DATA_W +: DATA_W] = 16'($urandom);
            end
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), rd,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
            cycleCheck();
        end
        idleCycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
